// File: rtl/wave_meas_if.sv
// Sample stream, measurement control and result bus of the waveform measurement block.
// The master drives the samples and control; the slave (wave_meas) returns the results.
interface wave_meas_if;
    logic [7:0]  ad_data;
    logic        ad_valid;
    logic [7:0]  trig_level;
    logic        meas_en;
    logic [31:0] freq_out;
    logic [7:0]  vmax;
    logic [7:0]  vmin;
    logic [7:0]  vpp;
    logic        meas_done;
    logic        busy;

    modport master (
        output ad_data, ad_valid, trig_level, meas_en,
        input  freq_out, vmax, vmin, vpp, meas_done, busy
    );

    modport slave (
        input  ad_data, ad_valid, trig_level, meas_en,
        output freq_out, vmax, vmin, vpp, meas_done, busy
    );
endinterface

// File: rtl/wave_meas.sv
// Gated frequency / peak measurement: counts hysteresis comparator rising crossings
// and tracks max/min of valid samples over GATE_CYCLES, then publishes the results.
module wave_meas #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter logic [7:0]  HYST        = 8'd4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    wave_meas_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GATE, UPDATE} state_t;

    localparam logic [31:0] LAST_CNT = 32'(GATE_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [8:0]  hi_sum;
    logic [8:0]  lo_diff;
    logic [7:0]  hi_th;
    logic [7:0]  lo_th;
    logic        cmp;
    logic        cmp_next;
    logic        rise;
    logic        gate_last;
    logic [31:0] gate_cnt;
    logic [31:0] cross_cnt;
    logic [31:0] cross_upd;
    logic [7:0]  run_max;
    logic [7:0]  run_min;
    logic [7:0]  max_upd;
    logic [7:0]  min_upd;
    logic        seen;
    logic        seen_upd;
    logic [31:0] freq_q;
    logic [7:0]  vmax_q;
    logic [7:0]  vmin_q;
    logic        done_q;

    // Ninth bit catches overflow/underflow so the thresholds saturate at the rails.
    assign hi_sum  = {1'b0, bus.trig_level} + {1'b0, HYST};
    assign lo_diff = {1'b0, bus.trig_level} - {1'b0, HYST};
    assign hi_th   = hi_sum[8]  ? 8'hFF : hi_sum[7:0];
    assign lo_th   = lo_diff[8] ? 8'h00 : lo_diff[7:0];

    always_comb begin
        cmp_next = cmp;
        if (bus.ad_valid) begin
            if (bus.ad_data >= hi_th) begin
                cmp_next = 1'b1;
            end else if (bus.ad_data <= lo_th) begin
                cmp_next = 1'b0;
            end
        end
    end

    assign rise      = cmp_next & ~cmp;
    assign gate_last = (gate_cnt == LAST_CNT);

    // Statistics including the current cycle, so the last gate cycle is part of the result.
    always_comb begin
        cross_upd = cross_cnt;
        max_upd   = run_max;
        min_upd   = run_min;
        seen_upd  = seen;
        if (rise && (cross_cnt != 32'hFFFF_FFFF)) begin
            cross_upd = cross_cnt + 32'd1;
        end
        if (bus.ad_valid) begin
            seen_upd = 1'b1;
            if (bus.ad_data > run_max) begin
                max_upd = bus.ad_data;
            end
            if (bus.ad_data < run_min) begin
                min_upd = bus.ad_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.meas_en) state_next = GATE;
            GATE: begin
                if (!bus.meas_en) begin
                    state_next = IDLE;
                end else if (gate_last) begin
                    state_next = UPDATE;
                end
            end
            UPDATE:  state_next = bus.meas_en ? GATE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            cmp   <= 1'b0;
        end else begin
            state <= state_next;
            cmp   <= cmp_next;
        end
    end

    // Accumulators are held clear outside GATE, so every gate entry starts fresh.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gate_cnt  <= 32'd0;
            cross_cnt <= 32'd0;
            run_max   <= 8'h00;
            run_min   <= 8'hFF;
            seen      <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt  <= gate_cnt + 32'd1;
            cross_cnt <= cross_upd;
            run_max   <= max_upd;
            run_min   <= min_upd;
            seen      <= seen_upd;
        end else begin
            gate_cnt  <= 32'd0;
            cross_cnt <= 32'd0;
            run_max   <= 8'h00;
            run_min   <= 8'hFF;
            seen      <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            freq_q <= 32'd0;
            vmax_q <= 8'h00;
            vmin_q <= 8'h00;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state == GATE) && bus.meas_en && gate_last) begin
                done_q <= 1'b1;
                if (seen_upd) begin
                    freq_q <= cross_upd;
                    vmax_q <= max_upd;
                    vmin_q <= min_upd;
                end else begin
                    freq_q <= 32'd0;
                    vmax_q <= 8'h00;
                    vmin_q <= 8'h00;
                end
            end
        end
    end

    assign bus.freq_out  = freq_q;
    assign bus.vmax      = vmax_q;
    assign bus.vmin      = vmin_q;
    assign bus.vpp       = vmax_q - vmin_q;
    assign bus.meas_done = done_q;
    assign bus.busy      = (state == GATE) || (state == UPDATE);
endmodule

// File: tb/tb_wave_meas.sv
// Randomized bench for wave_meas: a threshold/hysteresis reference model accumulates
// per-gate statistics from the driven samples and is compared with the published results.
module tb_wave_meas;
    localparam int GATE = 1000;
    localparam int HYST = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    bit          m_cmp;
    int unsigned m_cross;
    int          m_max;
    int          m_min;
    bit          m_seen;
    logic [31:0] e_freq;
    logic [7:0]  e_vmax;
    logic [7:0]  e_vmin;
    logic [7:0]  e_vpp;

    wave_meas_if bus();

    wave_meas #(
        .GATE_CYCLES (GATE),
        .HYST        (8'(HYST))
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Waveform generators indexed by cycle number since the start cycle.
    task automatic gen(input int kind, input int i, output bit v, output logic [7:0] d);
        int p;
        v = 1'b1;
        d = 8'h00;
        case (kind)
            0: begin
                p = i % 100;
                d = (p < 50) ? 8'((p * 255) / 49) : 8'(((99 - p) * 255) / 49);
            end
            1: d = (i % 2 == 1) ? 8'd130 : 8'd126;
            2: d = (i < 200) ? 8'd0 : 8'd255;
            3: v = 1'b0;
            default: begin
                v = ($urandom_range(0, 3) != 0);
                d = 8'($urandom_range(0, 255));
            end
        endcase
    endtask

    // Applies one cycle of inputs, advances the reference model and waits past the edge.
    task automatic drive(input bit v, input logic [7:0] d, input logic [7:0] t,
                         input bit en, input bit in_gate);
        int hi;
        int lo;
        bit nc;
        bus.ad_valid   = v;
        bus.ad_data    = d;
        bus.trig_level = t;
        bus.meas_en    = en;
        hi = int'(t) + HYST;
        if (hi > 255) hi = 255;
        lo = int'(t) - HYST;
        if (lo < 0) lo = 0;
        nc = m_cmp;
        if (v && int'(d) >= hi) nc = 1'b1;
        else if (v && int'(d) <= lo) nc = 1'b0;
        if (in_gate) begin
            if (nc && !m_cmp && m_cross != 32'hFFFF_FFFF) m_cross++;
            if (v) begin
                m_seen = 1'b1;
                if (int'(d) > m_max) m_max = int'(d);
                if (int'(d) < m_min) m_min = int'(d);
            end
        end
        m_cmp = nc;
        @(posedge clk);
        #1;
    endtask

    // Runs ngates consecutive gates from IDLE, checking each result; ends back in IDLE.
    task automatic run_gates(input int kind, input logic [7:0] t, input int ngates, input string name);
        bit v;
        logic [7:0] d;
        int i;
        int early;
        int busy_bad;
        i = 0;
        gen(kind, i, v, d);
        i++;
        drive(v, d, t, 1'b1, 1'b0);
        for (int g = 0; g < ngates; g++) begin
            m_cross = 0;
            m_max = 0;
            m_min = 255;
            m_seen = 1'b0;
            early = 0;
            busy_bad = 0;
            for (int c = 1; c <= GATE; c++) begin
                gen(kind, i, v, d);
                i++;
                drive(v, d, t, 1'b1, 1'b1);
                if (c < GATE && bus.meas_done !== 1'b0) early++;
                if (bus.busy !== 1'b1) busy_bad++;
            end
            if (m_seen) begin
                e_freq = m_cross;
                e_vmax = 8'(m_max);
                e_vmin = 8'(m_min);
                e_vpp  = 8'(m_max - m_min);
            end else begin
                e_freq = 32'd0;
                e_vmax = 8'd0;
                e_vmin = 8'd0;
                e_vpp  = 8'd0;
            end
            checks++;
            if (early !== 0) begin
                errors++;
                $display("[TB] FAIL %s early_done gate %0d: got %0d pulses, want 0", name, g, early);
            end
            checks++;
            if (busy_bad !== 0) begin
                errors++;
                $display("[TB] FAIL %s busy gate %0d: low in %0d cycles, want 0", name, g, busy_bad);
            end
            checks++;
            if (bus.meas_done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s meas_done gate %0d: got %b, want 1", name, g, bus.meas_done);
            end
            checks++;
            if (bus.freq_out !== e_freq) begin
                errors++;
                $display("[TB] FAIL %s freq_out gate %0d: got %0d, want %0d", name, g, bus.freq_out, e_freq);
            end
            checks++;
            if (bus.vmax !== e_vmax) begin
                errors++;
                $display("[TB] FAIL %s vmax gate %0d: got %0d, want %0d", name, g, bus.vmax, e_vmax);
            end
            checks++;
            if (bus.vmin !== e_vmin) begin
                errors++;
                $display("[TB] FAIL %s vmin gate %0d: got %0d, want %0d", name, g, bus.vmin, e_vmin);
            end
            checks++;
            if (bus.vpp !== e_vpp) begin
                errors++;
                $display("[TB] FAIL %s vpp gate %0d: got %0d, want %0d", name, g, bus.vpp, e_vpp);
            end
            gen(kind, i, v, d);
            i++;
            drive(v, d, t, (g < ngates - 1), 1'b0);
        end
        checks++;
        if (bus.meas_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle_after: done=%b busy=%b, want 0 0", name, bus.meas_done, bus.busy);
        end
        checks++;
        if (bus.freq_out !== e_freq || bus.vmax !== e_vmax || bus.vmin !== e_vmin) begin
            errors++;
            $display("[TB] FAIL %s hold: got %0d/%0d/%0d, want %0d/%0d/%0d", name,
                     bus.freq_out, bus.vmax, bus.vmin, e_freq, e_vmax, e_vmin);
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (bus.freq_out !== 32'd0 || bus.vmax !== 8'd0 || bus.vmin !== 8'd0 || bus.vpp !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %0d/%0d/%0d/%0d, want 0/0/0/0",
                     bus.freq_out, bus.vmax, bus.vmin, bus.vpp);
        end
        checks++;
        if (bus.meas_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: done=%b busy=%b, want 0 0", bus.meas_done, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_triangle;
        run_gates(0, 8'd128, 1, "triangle");
        checks++;
        if (bus.freq_out !== 32'd10 || bus.vmax !== 8'd255 || bus.vmin !== 8'd0 || bus.vpp !== 8'd255) begin
            errors++;
            $display("[TB] FAIL triangle_const: got %0d/%0d/%0d/%0d, want 10/255/0/255",
                     bus.freq_out, bus.vmax, bus.vmin, bus.vpp);
        end
    endtask

    task automatic test_hysteresis;
        run_gates(1, 8'd128, 1, "noise");
        checks++;
        if (bus.freq_out !== 32'd0 || bus.vpp !== 8'd4) begin
            errors++;
            $display("[TB] FAIL noise_const: freq=%0d vpp=%0d, want 0 4", bus.freq_out, bus.vpp);
        end
    endtask

    task automatic test_saturation;
        run_gates(2, 8'd253, 1, "saturate");
        checks++;
        if (bus.freq_out !== 32'd1) begin
            errors++;
            $display("[TB] FAIL saturate_const: freq=%0d, want 1", bus.freq_out);
        end
    endtask

    task automatic test_no_valid;
        run_gates(3, 8'd100, 1, "no_valid");
        checks++;
        if (bus.freq_out !== 32'd0 || bus.vmax !== 8'd0 || bus.vmin !== 8'd0 || bus.vpp !== 8'd0) begin
            errors++;
            $display("[TB] FAIL no_valid_const: got %0d/%0d/%0d/%0d, want 0/0/0/0",
                     bus.freq_out, bus.vmax, bus.vmin, bus.vpp);
        end
    endtask

    task automatic test_back_to_back;
        run_gates(4, 8'($urandom_range(20, 235)), 3, "back_to_back");
        run_gates(4, 8'($urandom_range(0, 3)), 1, "low_trig");
    endtask

    task automatic test_abort;
        bit v;
        logic [7:0] d;
        logic [7:0] t;
        int dones;
        t = 8'($urandom_range(40, 200));
        gen(4, 0, v, d);
        drive(v, d, t, 1'b1, 1'b0);
        for (int c = 1; c < 500; c++) begin
            gen(4, c, v, d);
            drive(v, d, t, 1'b1, 1'b0);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_busy_before: got %b, want 1", bus.busy);
        end
        gen(4, 500, v, d);
        drive(v, d, t, 1'b0, 1'b0);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_busy_after: got %b, want 0", bus.busy);
        end
        dones = 0;
        for (int c = 0; c < GATE + 100; c++) begin
            gen(4, c, v, d);
            drive(v, d, t, 1'b0, 1'b0);
            if (bus.meas_done !== 1'b0) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL abort_done: got %0d pulses, want 0", dones);
        end
        checks++;
        if (bus.freq_out !== e_freq || bus.vmax !== e_vmax || bus.vmin !== e_vmin || bus.vpp !== e_vpp) begin
            errors++;
            $display("[TB] FAIL abort_hold: got %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d",
                     bus.freq_out, bus.vmax, bus.vmin, bus.vpp, e_freq, e_vmax, e_vmin, e_vpp);
        end
    endtask

    task automatic test_reset_mid_gate;
        bit v;
        logic [7:0] d;
        logic [7:0] t;
        int dones;
        t = 8'($urandom_range(40, 200));
        gen(4, 0, v, d);
        drive(v, d, t, 1'b1, 1'b0);
        for (int c = 1; c <= 300; c++) begin
            gen(4, c, v, d);
            drive(v, d, t, 1'b1, 1'b0);
        end
        bus.meas_en  = 1'b0;
        bus.ad_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        m_cmp  = 1'b0;
        e_freq = 32'd0;
        e_vmax = 8'd0;
        e_vmin = 8'd0;
        e_vpp  = 8'd0;
        checks++;
        if (bus.freq_out !== 32'd0 || bus.vmax !== 8'd0 || bus.vmin !== 8'd0 || bus.vpp !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %0d/%0d/%0d/%0d, want 0/0/0/0",
                     bus.freq_out, bus.vmax, bus.vmin, bus.vpp);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.meas_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_flags: busy=%b done=%b, want 0 0", bus.busy, bus.meas_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 8'd0, t, 1'b0, 1'b0);
            if (bus.meas_done !== 1'b0 || bus.busy !== 1'b0) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_idle: got %0d active cycles, want 0", dones);
        end
        run_gates(4, t, 1, "after_reset");
    endtask

    initial begin
        clk            = 1'b0;
        rst_n          = 1'b0;
        errors         = 0;
        checks         = 0;
        m_cmp          = 1'b0;
        m_cross        = 0;
        m_max          = 0;
        m_min          = 255;
        m_seen         = 1'b0;
        e_freq         = 32'd0;
        e_vmax         = 8'd0;
        e_vmin         = 8'd0;
        e_vpp          = 8'd0;
        bus.ad_valid   = 1'b0;
        bus.ad_data    = 8'd0;
        bus.trig_level = 8'd128;
        bus.meas_en    = 1'b0;
        $display("[TB] wave_meas bench start");
        test_reset();
        test_triangle();
        test_hysteresis();
        test_saturation();
        test_no_valid();
        test_back_to_back();
        test_abort();
        test_reset_mid_gate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
